mmio_timer: RTL and testbench

Memory-mapped timer responder on the single-cycle CPU's data-memory port: the peripheral end of the CPU's load/store interface, sitting beside the data memory in the top level. It decodes the same address/write-data/write-enable/access-type signals the data memory receives and returns same-cycle read data. It provides a prescaled 32-bit up-counter, a compare register, a sticky match flag and a level interrupt. The top level muxes `dout` into the CPU read-data path when `hit` is high.

---
 rtl/mmio_timer.sv | 191 +++++++++++++++++++
 tb/tb_mmio_timer.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/mmio_timer.sv
// mmio_timer
// Memory-mapped timer that sits beside the data memory on the CPU load/store
// port. It provides a prescaled 32-bit up-counter, a compare register, a
// sticky match flag (write-1-to-clear) and a level interrupt.
//
// Ports:
//   clk   - CPU clock, all state updates on the rising edge
//   rstn  - asynchronous active-low reset
//   addr  - byte address from the CPU
//   din   - right-aligned store data
//   DMWr  - store strobe
//   ls    - access type: [1:0] size (00 byte, 01 half, 10 word, 11 none),
//           [2] unsigned load, [3] ignored
//   dout  - combinational load data, extended per ls
//   hit   - address falls in the 32-byte window at BASE
//   irq   - STATUS.MF & CTRL.IE
//
// Register map (offset): 0x00 CTRL {IE,AR,EN}, 0x04 COUNT, 0x08 CMP,
// 0x0C STATUS {MF} (W1C), 0x10 PRESC[15:0], 0x14-0x1C unmapped.
module mmio_timer #(
    parameter logic [31:0] BASE = 32'h0000_0400
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] addr,
    input  logic [31:0] din,
    input  logic        DMWr,
    input  logic [3:0]  ls,
    output logic [31:0] dout,
    output logic        hit,
    output logic        irq
);

    typedef enum logic [2:0] {
        REG_CTRL   = 3'd0,
        REG_COUNT  = 3'd1,
        REG_CMP    = 3'd2,
        REG_STATUS = 3'd3,
        REG_PRESC  = 3'd4
    } reg_sel_e;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_NONE = 2'b11
    } size_e;

    logic [2:0]  ctrl_q;
    logic [31:0] count_q;
    logic [31:0] cmp_q;
    logic        mf_q;
    logic [15:0] presc_q;
    logic [15:0] pcnt_q;

    reg_sel_e    sel;
    size_e       size;
    logic        access_ok;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] bmask;
    logic [31:0] rd_reg;
    logic [31:0] shifted;
    logic [31:0] merged;
    logic        wr;
    logic        en;
    logic        tick;
    logic        match;
    logic        unused_ls3;

    assign unused_ls3 = ls[3];

    assign hit  = (addr[31:5] == BASE[31:5]);
    assign sel  = reg_sel_e'(addr[4:2]);
    assign size = size_e'(ls[1:0]);

    // Access decode: alignment check, byte-lane enables and lane-replicated
    // store data so the merge below is a single mask operation.
    always_comb begin
        access_ok = 1'b0;
        be        = 4'b0000;
        wdata     = '0;
        case (size)
            SZ_BYTE: begin
                access_ok = 1'b1;
                be        = 4'b0001 << addr[1:0];
                wdata     = {4{din[7:0]}};
            end
            SZ_HALF: begin
                access_ok = ~addr[0];
                be        = addr[1] ? 4'b1100 : 4'b0011;
                wdata     = {2{din[15:0]}};
            end
            SZ_WORD: begin
                access_ok = (addr[1:0] == 2'b00);
                be        = 4'b1111;
                wdata     = din;
            end
            default: begin
                access_ok = 1'b0;
                be        = 4'b0000;
                wdata     = '0;
            end
        endcase
    end

    assign bmask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};

    always_comb begin
        rd_reg = '0;
        case (sel)
            REG_CTRL:   rd_reg = {29'd0, ctrl_q};
            REG_COUNT:  rd_reg = count_q;
            REG_CMP:    rd_reg = cmp_q;
            REG_STATUS: rd_reg = {31'd0, mf_q};
            REG_PRESC:  rd_reg = {16'd0, presc_q};
            default:    rd_reg = '0;
        endcase
    end

    assign shifted = rd_reg >> {addr[1:0], 3'b000};
    assign merged  = (rd_reg & ~bmask) | (wdata & bmask);
    assign wr      = DMWr & hit & access_ok;

    always_comb begin
        dout = '0;
        if (hit && access_ok) begin
            case (size)
                SZ_BYTE: dout = ls[2] ? {24'd0, shifted[7:0]}
                                      : {{24{shifted[7]}}, shifted[7:0]};
                SZ_HALF: dout = ls[2] ? {16'd0, shifted[15:0]}
                                      : {{16{shifted[15]}}, shifted[15:0]};
                SZ_WORD: dout = shifted;
                default: dout = '0;
            endcase
        end
    end

    assign en    = ctrl_q[0];
    assign tick  = en && (pcnt_q == presc_q);
    assign match = (count_q == cmp_q);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ctrl_q  <= '0;
            count_q <= '0;
            cmp_q   <= '0;
            mf_q    <= 1'b0;
            presc_q <= '0;
            pcnt_q  <= '0;
        end else begin
            if (wr && sel == REG_CTRL) begin
                ctrl_q <= merged[2:0];
            end
            if (wr && sel == REG_CMP) begin
                cmp_q <= merged;
            end
            if (wr && sel == REG_PRESC) begin
                presc_q <= merged[15:0];
            end

            // Prescaler restarts on a PRESC write or when EN is written 0.
            if (wr && sel == REG_PRESC) begin
                pcnt_q <= '0;
            end else if (wr && sel == REG_CTRL && !merged[0]) begin
                pcnt_q <= '0;
            end else if (tick) begin
                pcnt_q <= '0;
            end else if (en) begin
                pcnt_q <= pcnt_q + 16'd1;
            end

            // CPU write to COUNT overrides the tick update on the same edge.
            if (wr && sel == REG_COUNT) begin
                count_q <= merged;
            end else if (tick) begin
                count_q <= (match && ctrl_q[1]) ? 32'd0 : count_q + 32'd1;
            end

            // A match set wins over a W1C clear on the same edge.
            if (tick && match) begin
                mf_q <= 1'b1;
            end else if (wr && sel == REG_STATUS && be[0] && wdata[0]) begin
                mf_q <= 1'b0;
            end
        end
    end

    assign irq = mf_q & ctrl_q[2];

endmodule

// File: tb/tb_mmio_timer.sv
// Directed self-checking bench for mmio_timer.
module tb_mmio_timer;

    localparam logic [31:0] A_CTRL   = 32'h0000_0400;
    localparam logic [31:0] A_COUNT  = 32'h0000_0404;
    localparam logic [31:0] A_CMP    = 32'h0000_0408;
    localparam logic [31:0] A_STATUS = 32'h0000_040C;
    localparam logic [31:0] A_PRESC  = 32'h0000_0410;
    localparam logic [3:0]  LS_B  = 4'b0000;
    localparam logic [3:0]  LS_BU = 4'b0100;
    localparam logic [3:0]  LS_H  = 4'b0001;
    localparam logic [3:0]  LS_W  = 4'b0010;
    localparam logic [3:0]  LS_X  = 4'b0011;

    logic        clk;
    logic        rstn;
    logic [31:0] addr;
    logic [31:0] din;
    logic        DMWr;
    logic [3:0]  ls;
    logic [31:0] dout;
    logic        hit;
    logic        irq;

    int checks;
    int errors;

    mmio_timer #(.BASE(32'h0000_0400)) dut (
        .clk  (clk),
        .rstn (rstn),
        .addr (addr),
        .din  (din),
        .DMWr (DMWr),
        .ls   (ls),
        .dout (dout),
        .hit  (hit),
        .irq  (irq)
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;

    task automatic chk(input logic [31:0] got, input logic [31:0] exp, input string tag);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic chk_rd(input logic [31:0] a, input logic [3:0] l,
                          input logic [31:0] exp, input string tag);
        addr = a;
        ls   = l;
        DMWr = 1'b0;
        #1;
        chk(dout, exp, tag);
    endtask

    task automatic wr(input logic [31:0] a, input logic [3:0] l, input logic [31:0] d);
        addr = a;
        ls   = l;
        din  = d;
        DMWr = 1'b1;
        @(posedge clk);
        #1;
        DMWr = 1'b0;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rstn = 1'b0;
        addr = '0;
        din  = '0;
        DMWr = 1'b0;
        ls   = LS_W;

        // Reset state
        #1;
        chk_rd(A_CTRL, LS_W, 32'h0, "rst_ctrl");
        chk_rd(A_COUNT, LS_W, 32'h0, "rst_count");
        chk_rd(A_STATUS, LS_W, 32'h0, "rst_status");
        chk({31'd0, irq}, 32'h0, "rst_irq");
        @(posedge clk);
        #1;
        rstn = 1'b1;
        step(1);
        chk_rd(A_CMP, LS_W, 32'h0, "post_rst_cmp");

        // Auto-reload match with PRESC=0, CMP=5
        wr(A_PRESC, LS_W, 32'd0);
        wr(A_CMP, LS_W, 32'd5);
        wr(A_CTRL, LS_W, 32'h7);
        chk_rd(A_CTRL, LS_W, 32'h7, "ctrl_rb");
        chk_rd(A_COUNT, LS_W, 32'h0, "count_start");
        for (int i = 1; i <= 5; i++) begin
            step(1);
            chk_rd(A_COUNT, LS_W, 32'(i), "count_run");
            chk({31'd0, irq}, 32'h0, "irq_pre_match");
        end
        step(1);
        chk_rd(A_COUNT, LS_W, 32'h0, "count_reload");
        chk_rd(A_STATUS, LS_W, 32'h1, "mf_set");
        chk({31'd0, irq}, 32'h1, "irq_set");
        wr(A_STATUS, LS_W, 32'h1);
        chk({31'd0, irq}, 32'h0, "irq_w1c");
        chk_rd(A_STATUS, LS_W, 32'h0, "mf_w1c");
        wr(A_CTRL, LS_W, 32'h0);

        // Prescale by 4 and wrap
        wr(A_PRESC, LS_W, 32'd3);
        wr(A_CMP, LS_W, 32'h10);
        wr(A_COUNT, LS_W, 32'hFFFF_FFFF);
        wr(A_CTRL, LS_W, 32'h1);
        step(3);
        chk_rd(A_COUNT, LS_W, 32'hFFFF_FFFF, "presc_hold");
        step(1);
        chk_rd(A_COUNT, LS_W, 32'h0, "count_wrap");
        chk_rd(A_STATUS, LS_W, 32'h0, "wrap_no_mf");
        step(4);
        chk_rd(A_COUNT, LS_W, 32'h1, "presc_second");
        wr(A_CTRL, LS_W, 32'h0);
        step(3);
        chk_rd(A_COUNT, LS_W, 32'h1, "count_frozen");

        // Sub-word stores and loads
        wr(A_CMP, LS_W, 32'h1122_3344);
        wr(A_CMP + 32'd1, LS_B, 32'h0000_00AB);
        chk_rd(A_CMP, LS_W, 32'h1122_AB44, "byte_merge");
        chk_rd(A_CMP + 32'd1, LS_B, 32'hFFFF_FFAB, "lb_signed");
        chk_rd(A_CMP + 32'd1, LS_BU, 32'h0000_00AB, "lb_unsigned");
        chk_rd(A_CMP + 32'd2, LS_H, 32'h0000_1122, "lh_upper");
        chk_rd(A_CMP, LS_H, 32'hFFFF_AB44, "lh_lower");
        chk_rd(A_CMP + 32'd3, LS_B, 32'h0000_0011, "lb_top");

        // Same-edge priorities
        wr(A_PRESC, LS_W, 32'd0);
        wr(A_CMP, LS_W, 32'd3);
        wr(A_COUNT, LS_W, 32'd3);
        wr(A_CTRL, LS_W, 32'h5);
        wr(A_STATUS, LS_W, 32'h1);
        chk_rd(A_STATUS, LS_W, 32'h1, "mf_beats_w1c");
        chk({31'd0, irq}, 32'h1, "irq_beats_w1c");
        chk_rd(A_COUNT, LS_W, 32'd4, "no_ar_inc");
        wr(A_COUNT, LS_W, 32'h100);
        chk_rd(A_COUNT, LS_W, 32'h100, "cpu_beats_tick");
        step(1);
        chk_rd(A_COUNT, LS_W, 32'h101, "count_after_wr");
        wr(A_STATUS, LS_W, 32'h1);
        chk({31'd0, irq}, 32'h0, "irq_clear2");
        wr(A_CTRL, LS_W, 32'h0);
        step(2);
        chk_rd(A_COUNT, LS_W, 32'h103, "count_stop");

        // Ignored accesses and window decode
        wr(A_COUNT + 32'd2, LS_W, 32'hDEAD_BEEF);
        chk_rd(A_COUNT + 32'd2, LS_W, 32'h0, "misaligned_rd");
        wr(A_COUNT + 32'd1, LS_H, 32'h0000_FFFF);
        wr(A_COUNT, LS_X, 32'hDEAD_BEEF);
        wr(A_COUNT + 32'h20, LS_W, 32'h0);
        chk_rd(A_COUNT, LS_W, 32'h103, "ignored_stores");
        chk_rd(A_COUNT, 4'b1010, 32'h103, "ls3_ignored");
        wr(A_CTRL + 32'h14, LS_W, 32'hFFFF_FFFF);
        chk_rd(A_CTRL + 32'h14, LS_W, 32'h0, "unmapped_rd");
        wr(A_CTRL, LS_W, 32'hFFFF_FFF8);
        chk_rd(A_CTRL, LS_W, 32'h0, "ctrl_rsvd");
        chk_rd(A_CTRL + 32'h20, LS_W, 32'h0, "outside_rd");
        chk({31'd0, hit}, 32'h0, "hit_above");
        addr = A_CTRL + 32'h1C;
        #1;
        chk({31'd0, hit}, 32'h1, "hit_top");
        addr = A_CTRL - 32'd4;
        #1;
        chk({31'd0, hit}, 32'h0, "hit_below");

        // Reset while counting with irq asserted
        wr(A_COUNT, LS_W, 32'h0);
        wr(A_CMP, LS_W, 32'h0);
        wr(A_CTRL, LS_W, 32'h7);
        step(2);
        chk({31'd0, irq}, 32'h1, "irq_before_rst");
        #10;
        rstn = 1'b0;
        #1;
        chk({31'd0, irq}, 32'h0, "irq_async_rst");
        chk_rd(A_CTRL, LS_W, 32'h0, "ctrl_async_rst");
        chk_rd(A_STATUS, LS_W, 32'h0, "status_async_rst");
        @(posedge clk);
        #1;
        rstn = 1'b1;
        step(3);
        chk_rd(A_COUNT, LS_W, 32'h0, "count_stays_0");
        chk_rd(A_PRESC, LS_W, 32'h0, "presc_rst");
        chk({31'd0, irq}, 32'h0, "irq_after_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
